// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the receive, transmit and controller blocks.
package i2s_pkg;

  localparam int I2S_DATA_WIDTH = 32;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  // Receiver framing: hunting for the first ws boundary, or locked to it.
  typedef enum logic {
    SYNC_HUNT   = 1'b0,
    SYNC_LOCKED = 1'b1
  } sync_state_e;

endpackage

// File: rtl/i2s_receive_if.sv
// AXI4-Stream bundle carrying received I2S channel words.
interface i2s_receive_if
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = I2S_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] M_AXIS_TDATA;
  logic                  M_AXIS_TLAST;
  logic                  M_AXIS_TVALID;
  logic                  M_AXIS_TREADY;

  modport master (
    output M_AXIS_TDATA,
    output M_AXIS_TLAST,
    output M_AXIS_TVALID,
    input  M_AXIS_TREADY
  );

  modport slave (
    input  M_AXIS_TDATA,
    input  M_AXIS_TLAST,
    input  M_AXIS_TVALID,
    output M_AXIS_TREADY
  );

endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO: plain push/full on the write side, AXI-Stream style pop on the read side.
module axis_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop;
  logic             wr_en;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign m_valid = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = m_valid & m_ready;
  assign wr_en   = push & (~full | pop);

  // NOTE: storage is not reset; m_valid gates m_data, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign m_data = m_valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: rtl/i2s_receive.sv
// I2S slave receiver: frames the sd bit stream on sck rises and queues each
// complete channel word onto an AXI4-Stream master (TLAST = right channel).
module i2s_receive
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = I2S_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          M_AXIS_ACLK,
  input  logic          M_AXIS_ARESETN,
  input  logic          sck,
  input  logic          ws,
  input  logic          sd,
  i2s_receive_if.master m_axis,
  output logic          overflow,
  output logic          frame_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LSB_COUNT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] SAT_COUNT = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [1:0]            rst_sync;
  logic                  rst_n;
  logic                  sck_q;
  logic                  ws_prev;
  logic                  rise;
  logic                  boundary;
  logic [DATA_WIDTH-2:0] shreg;
  logic [CW-1:0]         bitcnt;
  sync_state_e           sync_q;
  sync_state_e           sync_d;
  logic                  push;
  logic                  bad_word;
  logic                  pop;
  logic                  fifo_full;
  logic [DATA_WIDTH:0]   push_word;
  logic [DATA_WIDTH:0]   fifo_word;

  // NOTE: reset asserts asynchronously but releases through two flops, so all state leaves reset on one edge.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) rst_sync <= '0;
    else                 rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign rise     = sck & ~sck_q;
  assign boundary = rise & (ws != ws_prev);
  // The bit sampled at a boundary is the LSB of the word that just ended.
  assign push_word = {ws_prev, shreg, sd};

  always_ff @(posedge M_AXIS_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      sck_q   <= 1'b0;
      ws_prev <= WS_LEFT;
      shreg   <= '0;
      bitcnt  <= '0;
    end else begin
      sck_q <= sck;
      if (rise) begin
        ws_prev <= ws;
        shreg   <= {shreg[DATA_WIDTH-3:0], sd};
        if (boundary)                  bitcnt <= '0;
        else if (bitcnt != SAT_COUNT)  bitcnt <= bitcnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge rst_n) begin
    if (!rst_n) sync_q <= SYNC_HUNT;
    else        sync_q <= sync_d;
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    sync_d   = sync_q;
    push     = 1'b0;
    bad_word = 1'b0;
    if (boundary) begin
      case (sync_q)
        SYNC_HUNT:   sync_d = SYNC_LOCKED;
        SYNC_LOCKED: begin
          if (bitcnt == LSB_COUNT) push     = 1'b1;
          else                     bad_word = 1'b1;
        end
        default:     sync_d = SYNC_HUNT;
      endcase
    end
  end

  assign pop = m_axis.M_AXIS_TVALID & m_axis.M_AXIS_TREADY;

  always_ff @(posedge M_AXIS_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push && fifo_full && !pop) overflow  <= 1'b1;
      if (bad_word)                  frame_err <= 1'b1;
    end
  end

  axis_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (M_AXIS_ACLK),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_word),
    .full      (fifo_full),
    .m_data    (fifo_word),
    .m_valid   (m_axis.M_AXIS_TVALID),
    .m_ready   (m_axis.M_AXIS_TREADY)
  );

  assign m_axis.M_AXIS_TDATA = fifo_word[DATA_WIDTH-1:0];
  assign m_axis.M_AXIS_TLAST = fifo_word[DATA_WIDTH];

endmodule

// File: doc/i2s_receive.md
# i2s_receive

I2S slave receiver that deserialises the serial data line (`sd`) from an external ADC/codec into 32-bit samples. It uses `sck` and `ws` from `i2s_controller` and presents each sample on an AXI4-Stream master port. It runs on `mclk` and is the capture-side counterpart of `i2s_transmit`: it feeds the processing/visualiser path, or `i2s_transmit` directly in loopback. Left/right words alternate on the stream, and TLAST marks the right-channel word.

## Interface
Parameters:
- `DATA_WIDTH`, 32, bits per channel word; exactly this many `sck` periods per `ws` half-frame.
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2.

Ports:
- `M_AXIS_ACLK`  in  1  block clock. Driven by `mclk`. All logic is synchronous to its rising edge.
- `M_AXIS_ARESETN`  in  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronised inside the block.
- `sck`  in  1  I2S bit clock from `i2s_controller`; derived from `mclk`.
- `ws`  in  1  word select from `i2s_controller`; 0 = left, 1 = right.
- `sd`  in  1  serial data, MSB first; changes on falling `sck`.
- `M_AXIS_TDATA`  out  DATA_WIDTH  received sample.
- `M_AXIS_TLAST`  out  1  1 = right-channel word, 0 = left-channel word.
- `M_AXIS_TVALID`  out  1  FIFO non-empty.
- `M_AXIS_TREADY`  in  1  downstream accept.
- `overflow`  out  1  sticky flag; set when a complete word is dropped because the FIFO is full.
- `frame_err`  out  1  sticky flag; set when a half-frame has the wrong bit count.

## Operation
- **Edge detect:** `sck_q` is registered every cycle. A rise event is the cycle where `sck`=1 and `sck_q`=0. All capture happens only on rise events.
- **Sampling:** on each rise event, sample `sd` and `ws`. `ws_prev` holds the `ws` value sampled at the previous rise event.
- **Framing (standard I2S, 1-bit delay):**
  - A rise event where sampled `ws` ≠ `ws_prev` is a boundary.
  - The bit sampled at a boundary is the LSB of the word belonging to `ws_prev`.
  - The next rise event samples the MSB of the new channel.
- **Shift register:** `shreg <= {shreg[DATA_WIDTH-2:0], sd}` on every rise event.
- **Bit counter:**
  - `bitcnt` clears to 0 at a boundary and increments at each non-boundary rise event.
  - It saturates at `DATA_WIDTH`.
- **Word completion at a boundary:**
  - If `synced`=1 and `bitcnt` = DATA_WIDTH-1, push `{last=ws_prev, data={shreg[DATA_WIDTH-2:0], sd}}` into the FIFO.
  - If `synced`=1 and `bitcnt` ≠ DATA_WIDTH-1, drop the word and set `frame_err`.
  - If `synced`=0, drop the word silently, then set `synced`.
- **Consequence of sync:** after reset, the first partial half-frame is never emitted. The first emitted word is the first fully received channel.
- **FIFO:**
  - Holds `FIFO_DEPTH` entries of {last, data}; pop on TVALID & TREADY.
  - Push while full and no pop in the same cycle: drop the new word, keep stored contents, set `overflow`.
  - Push and pop in the same cycle while full: accept both; count is unchanged.
  - Push and pop in the same cycle while empty: not possible, because TVALID=0.
- **Reset (at any time, including mid-word):**
  - FIFO empties; `shreg`, `bitcnt`, `synced`, `ws_prev`, `sck_q`, `overflow` and `frame_err` clear.
  - After release, the block resynchronises on the next `ws` boundary.

## Timing
- **Reset values:** TVALID=0, TDATA=0, TLAST=0, `overflow`=0, `frame_err`=0.
- **Latency:** the FIFO write occurs at the clock edge of the boundary rise event.
  - If the FIFO was empty, TVALID is high immediately after that edge.
  - From the LSB `sck` rise to TVALID: 1–2 `mclk` cycles.
- **AXIS rules:**
  - While TVALID=1 and TREADY=0, TDATA and TLAST are stable.
  - TVALID never drops without a handshake, except on reset.
  - Output order equals capture order.
- **Throughput:** the FIFO sustains one pop per cycle. One word arrives per `DATA_WIDTH` `sck` periods, so TREADY held high never overflows.
- **Clocking assumption:** `sck` ≤ `mclk`/2. No metastability sync is needed on `sck`/`ws`/`sd`, because all three are derived from `mclk`.

## Structure
- **Shared package `i2s_pkg`:**
  - `I2S_DATA_WIDTH` = 32.
  - `WS_LEFT` = 1'b0 and `WS_RIGHT` = 1'b1.
  - Shared with `i2s_transmit` and `i2s_controller`.
- **Sub-module `axis_sync_fifo`:**
  - Parameters: WIDTH = DATA_WIDTH+1, DEPTH = FIFO_DEPTH.
  - Interface: push/full, AXIS-style pop.
  - Reusable on the transmit side.
- **Top level:** the edge detect, framer and sticky flags stay in `i2s_receive`.

## Test plan
1. **Basic capture:** after reset, drive frames of left = 32'hA5A5_0001 and right = 32'h5A5A_0002 with TREADY=1.
   - Stream is A5A50001/TLAST=0, then 5A5A0002/TLAST=1, repeating.
   - No word is emitted from the partial half-frame in progress at reset release.
2. **Backpressure/overflow:** TREADY=0 for 6 complete words.
   - 4 words are held; `overflow` rises at the 5th word; words 5 and 6 are lost.
   - TDATA is stable throughout.
   - TREADY=1 then drains words 1–4 in order.
3. **Short frame:** one half-frame with 31 `sck` rises.
   - That word is dropped and `frame_err`=1.
   - The following correctly framed words are emitted unchanged.
4. **Reset mid-word:** assert `M_AXIS_ARESETN`=0 at bit 16 of a left word while the FIFO holds 2 words.
   - TVALID=0 and both flags are 0.
   - After release, the first output is the first complete word following a `ws` boundary.
5. **Bit order:** send left = 32'h8000_0001 and right = 32'hFFFF_FFFE.
   - Both are received exactly, proving MSB-first capture with the 1-bit `ws` delay.
6. **Loopback:** connect `i2s_transmit.sd` to `sd` and feed 2000 samples.
   - The received stream equals the transmitted sequence with channel/TLAST preserved.
   - No flags are set.
